// File: rtl/palette_sequencer.sv
// Gate Array palette: CPU register decode, ink storage, pixel shifter
// and the registered hardware colour feeding the colour decoder.
module palette_sequencer #(
    parameter int NPENS    = 16,
    parameter int COLOUR_W = 5
) (
    input  logic                CLK_n,
    input  logic                RESET,
    input  logic                CPU_WR,
    input  logic [7:0]          CPU_DATA,
    input  logic [7:0]          VIDEO_DATA,
    input  logic                LOAD,
    input  logic                PIXEL_EN,
    input  logic                HSYNC,
    input  logic                BORDER,
    output logic [COLOUR_W-1:0] COLOUR,
    output logic [1:0]          MODE
);

    localparam int PW = $clog2(NPENS + 1);

    typedef enum logic [1:0] {
        FN_PEN  = 2'b00,
        FN_INK  = 2'b01,
        FN_MODE = 2'b10,
        FN_NONE = 2'b11
    } fn_t;

    logic [COLOUR_W-1:0] r_ink [NPENS+1];
    logic [PW-1:0]       r_pen_sel;
    logic [1:0]          r_pend;
    logic                r_pend_v;
    logic [7:0]          r_sr;
    logic                r_hs_q;
    logic [COLOUR_W-1:0] r_colour;
    logic [1:0]          r_mode;

    fn_t                 w_fn;
    logic                w_wr_pen;
    logic                w_wr_ink;
    logic                w_wr_mode;
    logic                w_rise;
    logic [3:0]          w_pen;
    logic [PW-1:0]       w_pen_idx;
    logic [PW-1:0]       w_sel_next;

    assign w_fn      = fn_t'(CPU_DATA[7:6]);
    assign w_wr_pen  = CPU_WR && (w_fn == FN_PEN);
    assign w_wr_ink  = CPU_WR && (w_fn == FN_INK);
    assign w_wr_mode = CPU_WR && (w_fn == FN_MODE);
    assign w_rise    = HSYNC && !r_hs_q;

    assign w_sel_next = CPU_DATA[4] ? PW'(NPENS) : PW'(CPU_DATA[3:0]);

    // Pixel bit positions interleave across the byte per screen mode
    always_comb begin
        w_pen = 4'h0;
        case (r_mode)
            2'd0:    w_pen = {r_sr[1], r_sr[5], r_sr[3], r_sr[7]};
            2'd2:    w_pen = {3'b000, r_sr[7]};
            default: w_pen = {2'b00, r_sr[3], r_sr[7]};
        endcase
    end

    assign w_pen_idx = PW'(w_pen);

    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            for (int i = 0; i <= NPENS; i++) begin
                r_ink[i] <= '0;
            end
            r_pen_sel <= '0;
        end else begin
            if (w_wr_pen) begin
                r_pen_sel <= w_sel_next;
            end
            if (w_wr_ink) begin
                r_ink[r_pen_sel] <= CPU_DATA[COLOUR_W-1:0];
            end
        end
    end

    // A mode write coinciding with the HSYNC rise takes effect at once
    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            r_mode   <= 2'b00;
            r_pend   <= 2'b00;
            r_pend_v <= 1'b0;
            r_hs_q   <= 1'b0;
        end else begin
            r_hs_q <= HSYNC;
            if (w_wr_mode && w_rise) begin
                r_mode   <= CPU_DATA[1:0];
                r_pend   <= CPU_DATA[1:0];
                r_pend_v <= 1'b0;
            end else if (w_wr_mode) begin
                r_pend   <= CPU_DATA[1:0];
                r_pend_v <= 1'b1;
            end else if (w_rise && r_pend_v) begin
                r_mode   <= r_pend;
                r_pend_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            r_sr     <= 8'h00;
            r_colour <= '0;
        end else begin
            if (LOAD) begin
                r_sr <= VIDEO_DATA;
            end else if (PIXEL_EN) begin
                r_sr <= {r_sr[6:0], 1'b0};
            end
            r_colour <= BORDER ? r_ink[NPENS] : r_ink[w_pen_idx];
        end
    end

    assign COLOUR = r_colour;
    assign MODE   = r_mode;

endmodule

// File: tb/tb_palette_sequencer.sv
// Scoreboard bench: stimulus pushes expected COLOUR/MODE per cycle,
// a monitor pops and compares after every rising edge.
module tb_palette_sequencer;

    typedef struct packed {
        logic [4:0] colour;
        logic [1:0] mode;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       cpu_wr;
    logic [7:0] cpu_data;
    logic [7:0] video_data;
    logic       load;
    logic       pixel_en;
    logic       hsync;
    logic       border;
    logic [4:0] colour;
    logic [1:0] mode;

    exp_t exp_q[$];
    int   checks;
    int   fails;
    bit   started;
    bit   done;

    // reference model state
    int   m_ink[17];
    int   m_sel;
    int   m_mode;
    int   m_pend;
    bit   m_pv;
    int   m_sr;
    bit   m_hsq;

    logic cur_hs;
    logic cur_bd;
    logic cur_rst;

    palette_sequencer dut (
        .CLK_n     (clk),
        .RESET     (rst),
        .CPU_WR    (cpu_wr),
        .CPU_DATA  (cpu_data),
        .VIDEO_DATA(video_data),
        .LOAD      (load),
        .PIXEL_EN  (pixel_en),
        .HSYNC     (hsync),
        .BORDER    (border),
        .COLOUR    (colour),
        .MODE      (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bit_of(int v, int n);
        return (v >> n) & 1;
    endfunction

    // pixel index: which byte bits form the leftmost pixel's pen
    function automatic int pen_of(int sr, int md);
        int p;
        p = bit_of(sr, 7);
        if (md != 2) p += 2 * bit_of(sr, 3);
        if (md == 0) p += 4 * bit_of(sr, 5) + 8 * bit_of(sr, 1);
        return p;
    endfunction

    task automatic step(input bit wr, input int d,
                        input bit ld, input int vd, input bit pe);
        exp_t e;
        bit   rise;
        @(negedge clk);
        rst        = cur_rst;
        cpu_wr     = wr;
        cpu_data   = d[7:0];
        load       = ld;
        video_data = vd[7:0];
        pixel_en   = pe;
        hsync      = cur_hs;
        border     = cur_bd;
        if (cur_rst) begin
            foreach (m_ink[i]) m_ink[i] = 0;
            m_sel = 0; m_mode = 0; m_pend = 0;
            m_pv = 0; m_sr = 0; m_hsq = 0;
            e.colour = 5'h00;
        end else begin
            e.colour = cur_bd ? m_ink[16][4:0]
                              : m_ink[pen_of(m_sr, m_mode)][4:0];
            rise = cur_hs && !m_hsq;
            if (wr) begin
                case ((d >> 6) & 3)
                    0: m_sel = ((d >> 4) & 1) ? 16 : (d & 15);
                    1: m_ink[m_sel] = d & 31;
                    2: begin m_pend = d & 3; m_pv = 1; end
                    default: ;
                endcase
            end
            if (rise && m_pv) begin
                m_mode = m_pend;
                m_pv   = 0;
            end
            if (ld) m_sr = vd & 255;
            else if (pe) m_sr = (m_sr << 1) & 255;
            m_hsq = cur_hs;
        end
        e.mode = m_mode[1:0];
        exp_q.push_back(e);
        started = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int d);
        step(1, d, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (colour !== e.colour) begin
                fails++;
                $display("FAIL colour t=%0t got %h want %h",
                         $time, colour, e.colour);
            end
            checks++;
            if (mode !== e.mode) begin
                fails++;
                $display("FAIL mode t=%0t got %h want %h",
                         $time, mode, e.mode);
            end
        end else if (started && !done) begin
            checks++;
            fails++;
            $display("FAIL scoreboard_underflow t=%0t got 0 want 1",
                     $time);
        end
    end

    initial begin
        checks = 0; fails = 0;
        started = 0; done = 0;
        rst = 1; cpu_wr = 0; cpu_data = 0; video_data = 0;
        load = 0; pixel_en = 0; hsync = 0; border = 0;
        cur_hs = 0; cur_bd = 0; cur_rst = 1;
        foreach (m_ink[i]) m_ink[i] = 0;
        m_sel = 0; m_mode = 0; m_pend = 0;
        m_pv = 0; m_sr = 0; m_hsq = 0;

        idle(2);
        cur_rst = 0;
        // pen 3 = 0x0C, mode 0, load 0x88
        wr(8'h03); wr(8'h4C); wr(8'h80);
        cur_hs = 1; idle(1); cur_hs = 0; idle(1);
        step(0, 0, 1, 8'h88, 0);
        idle(2);
        // border ink
        wr(8'h10); wr(8'h54);
        cur_bd = 1; idle(2); cur_bd = 0; idle(2);
        // mode change on HSYNC rise only
        wr(8'h82); idle(2);
        cur_hs = 1; idle(2);
        wr(8'h81); idle(2);
        cur_hs = 0; idle(1); cur_hs = 1; idle(2); cur_hs = 0;
        // mode 2 pixel sequence
        wr(8'h82); cur_hs = 1; idle(1); cur_hs = 0; idle(1);
        wr(8'h00); wr(8'h40); wr(8'h01); wr(8'h4B);
        step(0, 0, 1, 8'hA5, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 1, 8'h5A, 1);
        idle(2);
        // ink write to displayed pen
        step(0, 0, 1, 8'hFF, 0);
        idle(1);
        wr(8'h55);
        idle(2);
        wr(8'hC0); idle(2);
        // mode write in the same cycle as the rise
        cur_hs = 1; wr(8'h80); idle(1); cur_hs = 0; idle(1);
        // reset discards pending mode
        wr(8'h83);
        cur_rst = 1; idle(1); cur_rst = 0;
        cur_hs = 1; idle(2); cur_hs = 0; idle(1);

        for (int n = 0; n < 3000; n++) begin
            bit w, l, p;
            int d, v;
            w = ($urandom_range(0, 3) == 0);
            d = $urandom_range(0, 255);
            l = ($urandom_range(0, 7) == 0);
            v = $urandom_range(0, 255);
            p = $urandom_range(0, 1);
            if ($urandom_range(0, 11) == 0) cur_hs = !cur_hs;
            cur_bd  = ($urandom_range(0, 7) == 0);
            cur_rst = ($urandom_range(0, 299) == 0);
            step(w, d, l, v, p);
        end
        cur_rst = 0;
        idle(1);

        @(negedge clk);
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        done = 1;
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/palette_sequencer.md
Name: palette_sequencer

Overview:
Owns the Gate Array palette. It decodes CPU palette/mode writes, holds the 16 pen inks plus the border ink, and shifts fetched video bytes into pen indices according to the screen mode. Each cycle it presents the selected 5-bit hardware colour to the colour decode stage (COLOUR[4:0]). Sits between the CPU/video-fetch logic and the RGB colour decoder.

Parameters:
NPENS, 16, number of ink pens (border is an extra register at index NPENS)
COLOUR_W, 5, width of one ink register / COLOUR output

Ports:
CLK_n  input  1  pixel clock, all logic on rising edge
RESET  input  1  synchronous active-high reset
CPU_WR  input  1  one-cycle strobe, Gate Array register write
CPU_DATA  input  8  write data; [7:6] = function
VIDEO_DATA  input  8  fetched screen byte
LOAD  input  1  capture VIDEO_DATA into shift register
PIXEL_EN  input  1  advance shift register to next pixel
HSYNC  input  1  horizontal sync from CRTC path
BORDER  input  1  outside display area; select border ink
COLOUR  output  5  hardware colour index to colour decoder (registered)
MODE  output  2  active screen mode

Behaviour:
- Clock and reset: one clock, CLK_n; RESET is synchronous and active-high. Everything updates on the CLK_n rising edge.
- Reset state: all 17 ink registers = 5'h00, pen_sel = 0, MODE = 2'b00, pending-mode valid = 0, pending mode = 0, shift register = 8'h00, HSYNC history = 0, COLOUR = 5'h00.
- RESET asserted mid-operation clears all state on that edge, including any pending mode change.
- CPU write decode, only when CPU_WR = 1:
  - [7:6] = 00, pen select: if bit 4 = 1, pen_sel = 16 (border); else pen_sel = bits [3:0].
  - [7:6] = 01, ink write: ink[pen_sel] <= bits [4:0].
  - [7:6] = 10, mode request: pending = bits [1:0], valid = 1. Bits [7:2] are not used here (ROM/interrupt control belongs elsewhere).
  - [7:6] = 11: ignored, no state change.
- Mode change timing:
  - hs_q registers HSYNC each cycle. A rise is HSYNC = 1 and hs_q = 0.
  - On a rise with valid = 1: MODE <= pending and valid <= 0. The new MODE is visible the following cycle.
  - Multiple mode writes before a rise: the last write wins.
  - Mode write in the same cycle as a rise: the new value is applied directly and valid ends at 0.
- Shift register:
  - LOAD = 1: sr <= VIDEO_DATA.
  - Otherwise PIXEL_EN = 1: sr <= {sr[6:0], 1'b0}.
  - LOAD has priority over PIXEL_EN when both are asserted.
  - Pixel cadence (pixels per byte) is set externally by the PIXEL_EN timing.
- Pen extraction, combinational from current sr and MODE:
  - mode 0: pen = {sr[1], sr[5], sr[3], sr[7]}
  - mode 1: pen = {2'b00, sr[3], sr[7]}
  - mode 2: pen = {3'b000, sr[7]}
  - mode 3: pen = {2'b00, sr[3], sr[7]}
- Output:
  - COLOUR <= BORDER ? ink[16] : ink[pen], computed from pre-shift sr. Latency is 1 cycle from sr/BORDER to COLOUR.
  - HSYNC does not force COLOUR; blanking is done downstream.
- Write/read collision: an ink write to the pen being displayed in the same cycle makes COLOUR show the old ink that cycle and the new ink from the next cycle.
- Pen selection is never re-decoded by PIXEL_EN or LOAD, only by CPU writes.

Test Plan:
- Reset, then write 0x03, 0x4C (pen 3 = 0x0C). Set MODE = 0 via 0x80 plus an HSYNC pulse. LOAD 0x88 (sr[7] = 1, sr[3] = 1 -> pen 3). -> COLOUR = 0x0C one cycle after sr holds 0x88.
- Write 0x10, 0x54 (border = 0x14). Assert BORDER. -> COLOUR = 0x14 next cycle regardless of sr. Deassert BORDER -> COLOUR returns to the pen ink.
- Write 0x82 with HSYNC low. -> MODE stays 00. Raise HSYNC -> MODE = 10 one cycle after the rise. Hold HSYNC high, then write 0x81 -> MODE stays 10 until the next rise.
- Mode 2: ink[0] = 0x00, ink[1] = 0x0B. LOAD 0xA5, then 7 PIXEL_EN strobes. -> COLOUR sequence 0B,00,0B,00,00,0B,00,0B. LOAD with PIXEL_EN in the same cycle -> sr = new byte, unshifted.
- Ink write to the displayed pen while a pixel is shown. -> old ink for 1 cycle, then new. CPU_DATA 0xC0 -> no register changes.
- Pending mode write, then RESET before the HSYNC rise. -> after reset MODE = 00, and a subsequent HSYNC rise leaves MODE = 00.
